// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - asynchronous SRAM controller for N 16-bit banks with byte lanes
// Bus-side request/ack handshake; SETUP, ACCESS (1+WAIT_STATES) and HOLD phases per transfer.
module sram_ctrl #(
  parameter int ADDR_W         = 18,
  parameter int NBANK          = 2,
  parameter int WAIT_STATES    = 1,
  parameter int SHARED_STROBES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [16*NBANK-1:0]   wdata,
  input  logic [2*NBANK-1:0]    be,
  output logic                  ack,
  output logic [16*NBANK-1:0]   rdata,
  output logic [ADDR_W-1:0]     ram_addr,
  input  logic [16*NBANK-1:0]   ram_data_read,
  output logic [16*NBANK-1:0]   ram_data_write,
  output logic                  ram_data_is_output,
  output logic [NBANK-1:0]      ram_ce_n,
  output logic [NBANK-1:0]      ram_ub_n,
  output logic [NBANK-1:0]      ram_lb_n,
  output logic [NBANK-1:0]      ram_we_n,
  output logic [NBANK-1:0]      ram_oe_n
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

  state_t                 state;
  logic [3:0]             cnt;
  logic                   we_q;
  logic [2*NBANK-1:0]     be_q;
  logic [NBANK-1:0]       sel_q;
  logic [NBANK-1:0]       strobe;
  logic [16*NBANK-1:0]    lane_mask;

  function automatic logic [NBANK-1:0] bank_sel(input logic [2*NBANK-1:0] b);
    logic [NBANK-1:0] r;
    for (int k = 0; k < NBANK; k++) r[k] = |b[2*k +: 2];
    return r;
  endfunction

  // hi selects the upper (1) or lower (0) byte-enable bit of each bank
  function automatic logic [NBANK-1:0] lanes(input logic [2*NBANK-1:0] b, input int hi);
    logic [NBANK-1:0] r;
    for (int k = 0; k < NBANK; k++) r[k] = b[2*k + hi];
    return r;
  endfunction

  assign sel_q  = bank_sel(be_q);
  assign strobe = (SHARED_STROBES != 0) ? {NBANK{|sel_q}} : sel_q;

  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < 2*NBANK; i++) lane_mask[8*i +: 8] = {8{be_q[i]}};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      cnt                <= '0;
      we_q               <= 1'b0;
      be_q               <= '0;
      ack                <= 1'b0;
      rdata              <= '0;
      ram_addr           <= '0;
      ram_data_write     <= '0;
      ram_data_is_output <= 1'b0;
      ram_ce_n           <= '1;
      ram_ub_n           <= '1;
      ram_lb_n           <= '1;
      ram_we_n           <= '1;
      ram_oe_n           <= '1;
    end else begin
      ack <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            we_q     <= we;
            be_q     <= be;
            ram_addr <= addr;
            ram_ce_n <= ~bank_sel(be);
            ram_lb_n <= ~lanes(be, 0);
            ram_ub_n <= ~lanes(be, 1);
            if (we) begin
              ram_data_write     <= wdata;
              ram_data_is_output <= 1'b1;
            end
            state <= SETUP;
          end
        end
        SETUP: begin
          cnt <= WS;
          if (we_q) ram_we_n <= ~strobe;
          else      ram_oe_n <= ~strobe;
          state <= ACCESS;
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            ram_we_n <= '1;
            ram_oe_n <= '1;
            ack      <= 1'b1;
            if (!we_q) rdata <= ram_data_read & lane_mask;
            state <= HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HOLD: begin
          // address and write data stay put; only the selects and pad enable release
          ram_ce_n           <= '1;
          ram_ub_n           <= '1;
          ram_lb_n           <= '1;
          ram_data_is_output <= 1'b0;
          state              <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
